// File: rtl/amci_arb_pkg.sv
// Shared types and helpers for the AMCI request arbiter.
package amci_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/amci_rr_picker.sv
// Combinational winner selection over the request vector.
// Define AMCI_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module amci_rr_picker
  import amci_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [IW-1:0]      winner,
  output logic               any
);

  logic [IW-1:0] idx;
  logic          found;

  assign any = |req;

`ifdef AMCI_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IW'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`else
  // Search starts one past the previous owner and wraps modulo NUM_REQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((32'(last) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/amci_arbiter.sv
// Shares one AXI4-Lite master's AMCI interface among NUM_REQ requesters,
// one transaction at a time. AMCI_ARB_FIXED_PRIO_EN selects fixed priority.
module amci_arbiter
  import amci_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_AXI_DATA_WIDTH = 32
) (
  input  logic                                 M_AXI_ACLK,
  input  logic                                 M_AXI_ARESETN,
  input  logic [NUM_REQ-1:0]                   REQ_VALID,
  input  logic [NUM_REQ-1:0]                   REQ_WRITE,
  input  logic [NUM_REQ*C_AXI_ADDR_WIDTH-1:0]  REQ_ADDR,
  input  logic [NUM_REQ*C_AXI_DATA_WIDTH-1:0]  REQ_WDATA,
  output logic [NUM_REQ-1:0]                   REQ_READY,
  output logic [NUM_REQ-1:0]                   RSP_VALID,
  output logic [C_AXI_DATA_WIDTH-1:0]          RSP_RDATA,
  output logic [$clog2(NUM_REQ)-1:0]           GRANT_ID,
  output logic                                 BUSY,
  output logic [C_AXI_ADDR_WIDTH-1:0]          AMCI_WADDR,
  output logic [C_AXI_DATA_WIDTH-1:0]          AMCI_WDATA,
  output logic                                 AMCI_WRITE,
  input  logic                                 AMCI_WIDLE,
  output logic [C_AXI_ADDR_WIDTH-1:0]          AMCI_RADDR,
  output logic                                 AMCI_READ,
  input  logic                                 AMCI_RIDLE,
  input  logic [C_AXI_DATA_WIDTH-1:0]          AMCI_RDATA
);

  localparam int unsigned IW = idx_w(NUM_REQ);
  localparam int unsigned AW = C_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_AXI_DATA_WIDTH;

  state_t              state;
  logic [IW-1:0]       grant;
  logic [IW-1:0]       last_grant;
  logic [IW-1:0]       winner;
  logic                any;
  logic                busy;
  logic                is_write;
  logic                first_wait;
  logic                wr_strobe;
  logic                rd_strobe;
  logic [AW-1:0]       addr;
  logic [DW-1:0]       wdata;
  logic [DW-1:0]       rsp_rdata;
  logic [NUM_REQ-1:0]  req_ready;
  logic [NUM_REQ-1:0]  rsp_valid;

  amci_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req    (REQ_VALID),
    .last   (last_grant),
    .winner (winner),
    .any    (any)
  );

  // Strobes and REQ_READY are registered at grant so they are high during ISSUE.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      busy       <= 1'b0;
      is_write   <= 1'b0;
      first_wait <= 1'b0;
      wr_strobe  <= 1'b0;
      rd_strobe  <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      rsp_rdata  <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any && AMCI_WIDLE && AMCI_RIDLE) begin
            grant     <= winner;
            busy      <= 1'b1;
            is_write  <= REQ_WRITE[winner];
            addr      <= REQ_ADDR[winner*AW +: AW];
            wdata     <= REQ_WDATA[winner*DW +: DW];
            wr_strobe <= REQ_WRITE[winner];
            rd_strobe <= !REQ_WRITE[winner];
            req_ready <= NUM_REQ'(1) << winner;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          last_grant <= grant;
          first_wait <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          // The master's idle flag may lag the strobe by a cycle.
          if (first_wait) begin
            first_wait <= 1'b0;
          end else if (is_write ? AMCI_WIDLE : AMCI_RIDLE) begin
            rsp_valid <= NUM_REQ'(1) << grant;
            rsp_rdata <= is_write ? '0 : AMCI_RDATA;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign REQ_READY  = req_ready;
  assign RSP_VALID  = rsp_valid;
  assign RSP_RDATA  = rsp_rdata;
  assign GRANT_ID   = grant;
  assign BUSY       = busy;
  assign AMCI_WADDR = addr;
  assign AMCI_RADDR = addr;
  assign AMCI_WDATA = wdata;
  assign AMCI_WRITE = wr_strobe;
  assign AMCI_READ  = rd_strobe;

endmodule

// File: doc/amci_arbiter.md
# amci_arbiter

Round-robin arbiter that shares one AXI4-Lite master's AMCI user interface (write: WADDR/WDATA/WRITE/WIDLE; read: RADDR/RDATA/READ/RIDLE) among NUM_REQ independent requesters. It sits between several register-access clients and the single AXI4-Lite master. It serialises their reads and writes, pulses the master's start strobes, waits for the matching idle flag, and returns completion (and read data) to the owning requester. Exactly one transaction is outstanding at any time.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- C_AXI_ADDR_WIDTH, 32, address width (AW)
- C_AXI_DATA_WIDTH, 32, data width (DW)
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  asynchronous, active-low reset
- REQ_VALID  in  NUM_REQ  per-requester request; held until matching REQ_READY
- REQ_WRITE  in  NUM_REQ  1 = write, 0 = read
- REQ_ADDR  in  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- REQ_WDATA  in  NUM_REQ*DW  packed write data
- REQ_READY  out  NUM_REQ  one-cycle accept pulse, one-hot
- RSP_VALID  out  NUM_REQ  one-cycle completion pulse, one-hot
- RSP_RDATA  out  DW  read data, valid with RSP_VALID; 0 for writes
- GRANT_ID  out  $clog2(NUM_REQ)  index of current/last owner
- BUSY  out  1  high from grant through completion
- AMCI_WADDR / AMCI_WDATA  out  AW / DW  to master
- AMCI_WRITE  out  1  to master, one-cycle start strobe
- AMCI_WIDLE  in  1  from master
- AMCI_RADDR  out  AW  to master
- AMCI_READ  out  1  to master, one-cycle start strobe
- AMCI_RIDLE  in  1  from master
- AMCI_RDATA  in  DW  from master

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any REQ_VALID is set and AMCI_WIDLE and AMCI_RIDLE are both 1:
  - pick winner g by round-robin, searching from last_grant+1 and wrapping modulo NUM_REQ;
  - latch addr/wdata/write of g into registers that drive AMCI_WADDR/WDATA/RADDR;
  - set GRANT_ID=g and BUSY=1, go to ISSUE.
- ISSUE (exactly one cycle):
  - drive AMCI_WRITE=1 (write) or AMCI_READ=1 (read), never both;
  - REQ_READY[g]=1; last_grant<=g; go to WAIT.
- WAIT:
  - ignore the idle flag during the first WAIT cycle (master's registered state is still updating);
  - from the second WAIT cycle, when the idle flag matching the transaction type is 1: RSP_VALID[g]<=1 next cycle, RSP_RDATA<=AMCI_RDATA (read) or 0 (write), BUSY<=0, go to IDLE.
- A new grant may be made in the same IDLE cycle that RSP_VALID is high.
- Requesters must keep REQ_VALID and their fields stable until REQ_READY. Withdrawing a request before REQ_READY is a protocol violation and its behaviour is undefined. A requester may raise a new request in the cycle after its RSP_VALID.
- Non-winning requesters wait; no starvation with round-robin. The worst-case wait is NUM_REQ-1 transactions.

## Timing
- Reset (async assert, sync deassert by system) puts all outputs at 0:
  - AMCI_WRITE=0, AMCI_READ=0, REQ_READY=0, RSP_VALID=0, BUSY=0, GRANT_ID=0, RSP_RDATA=0, AMCI addr/data=0;
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transaction drops it silently. No RSP_VALID is issued.
- Latency, request in IDLE with master idle:
  - REQ_READY at +1;
  - AMCI strobe at +1;
  - RSP_VALID one cycle after the master's idle flag returns.
- All outputs are registered. There is no combinational path from REQ_* or AMCI_* inputs to outputs.

## Configuration
- AMCI_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins. last_grant is unused.
- Undefined (default): round-robin as above.

## Structure
- Package amci_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT);
  - IDX_W = $clog2(NUM_REQ) helper function.
- Sub-module amci_rr_picker: combinational; takes request vector and last_grant, returns winner index and any-valid flag. The fixed-priority variant is selected inside it by the macro.

## Test plan
- Single read: req1 reads 0x0000_0010, master returns 0xDEAD_BEEF -> REQ_READY[1] at +1, one AMCI_READ pulse, RSP_VALID[1] with RSP_RDATA=0xDEAD_BEEF, no other pulses.
- Single write: req2 writes 0x1234_5678 to 0x0000_0020 -> one AMCI_WRITE pulse with those values, RSP_VALID[2], RSP_RDATA=0.
- All four requesters valid continuously after reset -> grant order 0,1,2,3,0,...; with AMCI_ARB_FIXED_PRIO_EN, req0 is served on every grant.
- Master held busy: AMCI_WIDLE=0 for 20 cycles before first grant -> no strobe until idle; then exactly one strobe.
- Back-to-back: req0 write, then read, issued immediately after its RSP_VALID -> second grant in the cycle after RSP_VALID; AMCI_WRITE and AMCI_READ never high together.
- Reset during WAIT -> all outputs 0 within the reset cycle, no RSP_VALID; after release, the pending request is re-granted normally.
